circuitshort_sweep: RTL and testbench

Synchronous stimulus sequencer and response checker that sits directly upstream of the `circuitshort` combinational block. It drives `circuitshort`'s three inputs through all eight input combinations and samples its output `f` for each combination. It compares the captured 8-entry truth table against an expected table and reports per-vector mismatches, an error count and pass/fail. It is the hardware replacement for the manual exhaustive sweep, so the check can run in-system.

---
 rtl/circuitshort_sweep.sv | 119 +++++++++++
 tb/tb_circuitshort_sweep.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/circuitshort_sweep.sv
// circuitshort_sweep
//   Exhaustive stimulus sequencer and response checker for the three-input
//   combinational block `circuitshort`. On `start` it drives {a,b,c} through
//   000..111 and holds each vector for SETTLE cycles. On the last cycle of
//   each vector it samples `f` and compares the captured truth table
//   against EXPECTED.
//
// Parameters
//   SETTLE    cycles each vector is held before `f` is sampled (1..15)
//   EXPECTED  expected truth table; bit i is f for {a,b,c} == i
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   begins a sweep when sampled high while idle
//   a, b, c    out  registered stimulus (a is the MSB of the vector index)
//   f          in   circuitshort output, combinational from a/b/c
//   busy       out  high while a sweep is in progress
//   done       out  one-cycle pulse when a sweep completes
//   result     out  captured f, bit i for vector i
//   mismatch   out  result ^ EXPECTED, filled in as each vector is sampled
//   err_count  out  number of set bits in mismatch (0..8)
//   pass       out  high after a completed sweep with no mismatches
module circuitshort_sweep #(
  parameter int         SETTLE   = 4,
  parameter logic [7:0] EXPECTED = 8'hE8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       c,
  input  logic       f,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic [7:0] mismatch,
  output logic [3:0] err_count,
  output logic       pass
);

  localparam logic IDLE = 1'b0;
  localparam logic RUN  = 1'b1;

  // Last settle count of a vector; the edge on which cnt equals this value
  // is the sample edge.
  localparam logic [3:0] LAST = 4'(SETTLE - 1);

  logic       state;
  logic [2:0] idx;
  logic [3:0] cnt;
  logic [2:0] vec;
  logic       miss;

  assign a = vec[2];
  assign b = vec[1];
  assign c = vec[0];

  // f is valid only on the sample edge; miss is ignored otherwise.
  assign miss = f ^ EXPECTED[idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= 3'd0;
      cnt       <= 4'd0;
      vec       <= 3'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      result    <= 8'h00;
      mismatch  <= 8'h00;
      err_count <= 4'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            busy      <= 1'b1;
            vec       <= 3'd0;
            idx       <= 3'd0;
            cnt       <= 4'd0;
            result    <= 8'h00;
            mismatch  <= 8'h00;
            err_count <= 4'd0;
            pass      <= 1'b0;
          end
        end
        RUN: begin
          if (cnt != LAST) begin
            cnt <= cnt + 4'd1;
          end else begin
            result[idx]   <= f;
            mismatch[idx] <= miss;
            // At most 8 increments per sweep, so the 4-bit count cannot wrap.
            if (miss) begin
              err_count <= err_count + 4'd1;
            end
            if (idx == 3'd7) begin
              // The vector stays at 111 once the sweep ends.
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_count == 4'd0) && !miss;
            end else begin
              idx <= idx + 3'd1;
              vec <= idx + 3'd1;
              cnt <= 4'd0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_circuitshort_sweep.sv
// Testbench for circuitshort_sweep. The circuit under test is modelled as
// an 8-bit truth table `tt` indexed by {a,b,c}. Expected sweep results
// therefore follow directly from the table: result = tt,
// mismatch = tt ^ EXPECTED, err_count = popcount, and pass = no mismatches.
module tb_circuitshort_sweep;

  localparam int         S   = 4;
  localparam logic [7:0] EXP = 8'hE8;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] tt    = 8'hE8;
  logic       a, b, c, f, busy, done, pass;
  logic [7:0] result, mismatch;
  logic [3:0] err_count;

  logic       start1 = 1'b0;
  logic       a1, b1, c1, f1, busy1, done1, pass1;
  logic [7:0] result1, mismatch1;
  logic [3:0] err_count1;

  assign f  = tt[{a, b, c}];
  assign f1 = tt[{a1, b1, c1}];

  circuitshort_sweep #(.SETTLE(S), .EXPECTED(EXP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .c(c), .f(f),
    .busy(busy), .done(done), .result(result), .mismatch(mismatch),
    .err_count(err_count), .pass(pass)
  );

  circuitshort_sweep #(.SETTLE(1), .EXPECTED(EXP)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .c(c1), .f(f1),
    .busy(busy1), .done(done1), .result(result1), .mismatch(mismatch1),
    .err_count(err_count1), .pass(pass1)
  );

  always #5 clk = ~clk;

  int npass  = 0;
  int ntotal = 0;

  typedef struct {
    logic [7:0] tt;
    logic [7:0] res;
    logic [7:0] mis;
    int         err;
    logic       pas;
  } rec_t;

  rec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  // Reference model: expected sweep outcome for a given truth table.
  function automatic rec_t model(input logic [7:0] t);
    rec_t r;
    r.tt  = t;
    r.res = t;
    r.mis = t ^ EXP;
    r.err = $countones(r.mis);
    r.pas = (r.err == 0);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_sweep(input bit hold);
    start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_abc"}, 32'({a, b, c}), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_pass"}, 32'(pass), 32'd0);
    chk({tag, "_result"}, 32'(result), 32'd0);
    chk({tag, "_mismatch"}, 32'(mismatch), 32'd0);
    chk({tag, "_err"}, 32'(err_count), 32'd0);
  endtask

  // Called just after the start edge (edge 0); returns just after edge 8*S.
  // mode 1 pulses start at edge 10 and on the final sample edge.
  task automatic body(input rec_t r, input int mode);
    int         n;
    logic [7:0] m;
    tt = r.tt;
    for (int k = 0; k < 8 * S; k++) begin
      n = k / S;
      m = 8'((1 << n) - 1);
      chk("vec", 32'({a, b, c}), 32'(n));
      chk("busy_run", 32'(busy), 32'd1);
      chk("done_early", 32'(done), 32'd0);
      chk("pass_run", 32'(pass), 32'd0);
      chk("result_part", 32'(result), 32'(r.res & m));
      chk("mismatch_part", 32'(mismatch), 32'(r.mis & m));
      chk("err_part", 32'(err_count), 32'($countones(r.mis & m)));
      if (mode == 1) begin
        if (k == 9) start = 1'b1;
        if (k == 10) start = 1'b0;
        if (k == 8 * S - 1) start = 1'b1;
      end
      tick();
    end
    if (mode == 1) start = 1'b0;
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_end", 32'(busy), 32'd0);
    chk("vec_end", 32'({a, b, c}), 32'd7);
    chk("result", 32'(result), 32'(r.res));
    chk("mismatch", 32'(mismatch), 32'(r.mis));
    chk("err_count", 32'(err_count), 32'(r.err));
    chk("pass", 32'(pass), 32'(r.pas));
  endtask

  task automatic finish_idle(input rec_t r);
    tick();
    chk("done_clear", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    repeat (3) tick();
    chk("result_hold", 32'(result), 32'(r.res));
    chk("mismatch_hold", 32'(mismatch), 32'(r.mis));
    chk("err_hold", 32'(err_count), 32'(r.err));
    chk("pass_hold", 32'(pass), 32'(r.pas));
    chk("vec_hold", 32'({a, b, c}), 32'd7);
  endtask

  initial begin
    rec_t r;
    tbl[0] = '{tt: 8'hE8, res: 8'hE8, mis: 8'h00, err: 0, pas: 1'b1};  // majority
    tbl[1] = '{tt: 8'h00, res: 8'h00, mis: 8'hE8, err: 4, pas: 1'b0};  // stuck-at-0
    tbl[2] = '{tt: 8'hFE, res: 8'hFE, mis: 8'h16, err: 3, pas: 1'b0};  // OR
    tbl[3] = '{tt: 8'hFF, res: 8'hFF, mis: 8'h17, err: 4, pas: 1'b0};  // stuck-at-1
    tbl[4] = '{tt: 8'h17, res: 8'h17, mis: 8'hFF, err: 8, pas: 1'b0};  // all wrong

    // Power-up reset state.
    #12;
    chk_zero("reset");
    chk("reset_busy1", 32'(busy1), 32'd0);
    chk("reset_result1", 32'(result1), 32'd0);
    rst_n = 1'b1;
    tick();

    // Table-driven sweeps.
    foreach (tbl[i]) begin
      begin_sweep(1'b0);
      body(tbl[i], 0);
      finish_idle(tbl[i]);
    end

    // Start pulses while busy, including the final sample edge, are ignored.
    begin_sweep(1'b0);
    body(tbl[0], 1);
    finish_idle(tbl[0]);

    // Asynchronous reset while vector 3 is driven.
    tt = 8'hFE;
    begin_sweep(1'b0);
    repeat (13) tick();
    chk("vec3_before_reset", 32'({a, b, c}), 32'd3);
    chk("result_before_reset", 32'(result), 32'h06);
    #2 rst_n = 1'b0;
    #1 chk_zero("midreset");
    #1 rst_n = 1'b1;
    tick();
    chk("idle_after_reset", 32'(busy), 32'd0);
    chk("vec_after_reset", 32'({a, b, c}), 32'd0);
    begin_sweep(1'b0);
    body(tbl[0], 0);
    finish_idle(tbl[0]);

    // start held high: the second sweep begins on the edge after done.
    begin_sweep(1'b1);
    body(tbl[2], 0);
    tick();
    start = 1'b0;
    body(tbl[1], 0);
    finish_idle(tbl[1]);

    // Random truth tables against the reference model.
    for (int i = 0; i < 6; i++) begin
      r = model(8'($urandom_range(0, 255)));
      begin_sweep(1'b0);
      body(r, 0);
      finish_idle(r);
    end

    // Minimum settle time: the vector advances every cycle.
    tt = 8'hE8;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("s1_vec", 32'({a1, b1, c1}), 32'(k));
      chk("s1_busy", 32'(busy1), 32'd1);
      chk("s1_done_early", 32'(done1), 32'd0);
      tick();
    end
    chk("s1_done", 32'(done1), 32'd1);
    chk("s1_busy_end", 32'(busy1), 32'd0);
    chk("s1_result", 32'(result1), 32'hE8);
    chk("s1_mismatch", 32'(mismatch1), 32'h00);
    chk("s1_err", 32'(err_count1), 32'd0);
    chk("s1_pass", 32'(pass1), 32'd1);
    tick();
    chk("s1_done_clear", 32'(done1), 32'd0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
